permute_selftest_ctrl: RTL

PERMUTE_SELFTEST_CTRL -- requirements
Module: permute_selftest_ctrl

---
 rtl/permute_selftest_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/permute_selftest_ctrl.sv
// Self-test controller for a field-element permutation block.
// Feeds LFSR-derived stimulus to the permutation, folds every result into a
// rotating MISR signature, tracks worst-case call latency and flags timeouts.
module permute_selftest_ctrl #(
  parameter int N_BITS  = 254,
  parameter int N_ELEMS = 3,
  parameter int N_ITERS = 16,
  parameter int TIMEOUT = 1024,
  parameter int LAT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_BITS-1:0]            seed,
  input  logic [N_BITS-1:0]            exp_sig,
  output logic [N_ELEMS*N_BITS-1:0]    dut_in,
  output logic                         dut_valid,
  input  logic [N_ELEMS*N_BITS-1:0]    dut_out,
  input  logic                         dut_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         err_timeout,
  output logic [N_BITS-1:0]            signature,
  output logic [$clog2(N_ITERS+1)-1:0] iter_cnt,
  output logic [LAT_W-1:0]             max_lat
);

  localparam int CNT_W = $clog2(N_ITERS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state, state_next;
  logic [N_BITS-1:0]  lfsr, lfsr_next, seed_eff, out_xor, sig_next;
  logic [LAT_W-1:0]   lat, cur_lat;
  logic [CNT_W-1:0]   iter_next;
  logic               accept_start, take_ready, timeout_hit, last_call, timeout_now;

  function automatic logic [N_BITS-1:0] rotl(input logic [N_BITS-1:0] v, input int k);
    int s;
    s = k % N_BITS;
    if (s == 0) return v;
    return (v << s) | (v >> (N_BITS - s));
  endfunction

  // Element k of a stimulus word is the LFSR value rotated left by k bits.
  function automatic logic [N_ELEMS*N_BITS-1:0] spread(input logic [N_BITS-1:0] v);
    logic [N_ELEMS*N_BITS-1:0] r;
    r = '0;
    for (int k = 0; k < N_ELEMS; k++) r[k*N_BITS +: N_BITS] = rotl(v, k);
    return r;
  endfunction

  // Datapath helpers: next LFSR, folded result, next signature and latency.
  always_comb begin
    out_xor = '0;
    for (int k = 0; k < N_ELEMS; k++) out_xor = out_xor ^ dut_out[k*N_BITS +: N_BITS];
    seed_eff    = (seed == '0) ? N_BITS'(1) : seed;
    lfsr_next   = lfsr ^ (lfsr << 7) ^ (lfsr >> 9);
    sig_next    = rotl(signature, 1) ^ out_xor;
    cur_lat     = (&lat) ? lat : lat + LAT_W'(1);
    iter_next   = iter_cnt + CNT_W'(1);
    last_call   = (32'(iter_next) == N_ITERS);
    timeout_now = (32'(cur_lat) >= TIMEOUT);
  end

  // State register; reset drops straight back to IDLE even mid-run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic plus one-cycle control strobes for the datapath.
  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    take_ready   = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (dut_ready) begin
          take_ready = 1'b1;
          state_next = last_call ? DONE : ISSUE;
        end else if (timeout_now) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Run state: stimulus, signature, counters and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr        <= N_BITS'(1);
      dut_in      <= '0;
      signature   <= '0;
      iter_cnt    <= '0;
      max_lat     <= '0;
      lat         <= '0;
      pass        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (accept_start) begin
        lfsr        <= seed_eff;
        dut_in      <= spread(seed_eff);
        signature   <= '0;
        iter_cnt    <= '0;
        max_lat     <= '0;
        pass        <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (state == ISSUE)     lat <= '0;
      else if (state == WAIT) lat <= cur_lat;
      if (take_ready) begin
        signature <= sig_next;
        iter_cnt  <= iter_next;
        lfsr      <= lfsr_next;
        if (cur_lat > max_lat) max_lat <= cur_lat;
        if (last_call) pass   <= (sig_next == exp_sig);
        else           dut_in <= spread(lfsr_next);
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
        pass        <= 1'b0;
      end
    end
  end

  assign dut_valid = (state == ISSUE);
  assign busy      = (state == ISSUE) || (state == WAIT);
  assign done      = (state == DONE);

endmodule
